// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data ports.
// Define ARB_ROUND_ROBIN_EN to alternate tie grants; otherwise ties go to data.
module mem_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_f,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_m,
    output logic              bus_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic       OWN_IF   = 1'b0;
    localparam logic       OWN_DM   = 1'b1;
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t            state_q, state_d;
    logic              own_q, own_d;
    logic              last_grant_q, last_grant_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              bus_err_q, bus_err_d;

    logic              tie_to_dm;
    logic              grant_dm;
    logic              any_req;
    logic              timed_out;
    logic [DATA_W-1:0] rd_word;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_to_dm = (last_grant_q == OWN_IF);
`else
    assign tie_to_dm = 1'b1;
`endif

    assign any_req   = if_req | dm_req;
    assign grant_dm  = dm_req & (~if_req | tie_to_dm);
    assign timed_out = (wait_cnt_q == WAIT_LIM);
    // A write returns zero on its read-data bus.
    assign rd_word   = mem_we_q ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            own_q        <= OWN_IF;
            last_grant_q <= OWN_IF;
            wait_cnt_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            own_q        <= own_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        own_d        = own_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    own_d   = grant_dm ? OWN_DM : OWN_IF;
                end
            end
            BUSY: begin
                if (mem_ready || timed_out) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d      = IDLE;
                last_grant_d = own_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion results are registered on the BUSY->DONE edge so the valid
    // pulse coincides with the single DONE cycle.
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_dm & dm_we;
                    mem_addr_d  = grant_dm ? dm_addr : if_addr;
                    mem_wdata_d = grant_dm ? dm_wdata : '0;
                    wait_cnt_d  = '0;
                end
            end
            BUSY: begin
                if (mem_ready || timed_out) begin
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = ~mem_ready;
                    if (own_q == OWN_DM) begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = mem_ready ? rd_word : '0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_ready ? rd_word : '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign bus_err   = bus_err_q;
    assign stall_f   = if_req & ~if_valid_q;
    assign stall_m   = dm_req & ~dm_valid_q;

endmodule
